// File: rtl/i_mem_ring_loader_if.sv
// Bundle of the loader's control, word-source, ring-request and status
// signals. The loader side uses the master modport; the surrounding system
// (sequencer, word source, I_MEM ring) uses the slave modport.
//
// Handshake rules:
//   - Word source: a word transfers on every rising QClk edge where
//     SrcValidQ500H and SrcReadyQ500H are both 1. The source holds data
//     stable while valid is high and not yet accepted. Ready never depends
//     combinationally on valid.
//   - Ring request: F2C_ReqValidQ503H is high for exactly one cycle per
//     request. The ring always accepts, so there is no ready signal.
//   - Ring response: F2C_RspIMemValidQ504H qualifies F2C_I_MemRspDataQ504H
//     for one cycle. It is only looked at while a read is outstanding.

typedef enum logic [1:0] {
  OP_RD = 2'b00,
  OP_WR = 2'b01
} t_opcode;

interface i_mem_ring_loader_if;
  logic        StartQ500H;
  logic        VerifyEnQ500H;
  logic [31:0] BaseAddrQ500H;
  logic [15:0] LenWordsQ500H;

  logic        SrcValidQ500H;
  logic [31:0] SrcDataQ500H;
  logic        SrcReadyQ500H;

  logic        F2C_ReqValidQ503H;
  t_opcode     F2C_ReqOpcodeQ503H;
  logic [31:0] F2C_ReqAddressQ503H;
  logic [31:0] F2C_ReqDataQ503H;

  logic        F2C_RspIMemValidQ504H;
  logic [31:0] F2C_I_MemRspDataQ504H;

  logic        BusyQ500H;
  logic        DoneQ500H;
  logic        ErrorQ500H;
  logic [31:0] ErrAddrQ500H;

  // Current loader FSM state, for debug and checkers.
  logic [2:0]  DbgStateQ500H;

  modport master (
    input  StartQ500H, VerifyEnQ500H, BaseAddrQ500H, LenWordsQ500H,
    input  SrcValidQ500H, SrcDataQ500H,
    input  F2C_RspIMemValidQ504H, F2C_I_MemRspDataQ504H,
    output SrcReadyQ500H,
    output F2C_ReqValidQ503H, F2C_ReqOpcodeQ503H, F2C_ReqAddressQ503H, F2C_ReqDataQ503H,
    output BusyQ500H, DoneQ500H, ErrorQ500H, ErrAddrQ500H,
    output DbgStateQ500H
  );

  modport slave (
    output StartQ500H, VerifyEnQ500H, BaseAddrQ500H, LenWordsQ500H,
    output SrcValidQ500H, SrcDataQ500H,
    output F2C_RspIMemValidQ504H, F2C_I_MemRspDataQ504H,
    input  SrcReadyQ500H,
    input  F2C_ReqValidQ503H, F2C_ReqOpcodeQ503H, F2C_ReqAddressQ503H, F2C_ReqDataQ503H,
    input  BusyQ500H, DoneQ500H, ErrorQ500H, ErrAddrQ500H,
    input  DbgStateQ500H
  );
endinterface

// File: rtl/i_mem_ring_loader.sv
// I_MEM ring loader: streams LenWords words from a valid/ready source into
// I_MEM over the ring as write requests, then optionally re-reads each word
// (one read outstanding at a time) and compares it against a second copy of
// the stream supplied by the source. The first mismatch or response timeout
// sets a sticky error with the failing request address.

module i_mem_ring_loader #(
  parameter int MAX_WORDS   = 1024,
  parameter int RSP_TIMEOUT = 8,
  // Highest byte-address bit inside I_MEM; addresses wrap modulo 2**(MSB_I_MEM+1).
  parameter int MSB_I_MEM   = 15,
  // Field of the ring address that selects the I_MEM region.
  parameter int MSB_REGION  = 31,
  parameter int LSB_REGION  = 28,
  parameter logic [MSB_REGION-LSB_REGION:0] I_MEM_REGION = 4'h4
) (
  input logic QClk,
  input logic RstQnnnH,
  i_mem_ring_loader_if.master bus
);

  // Word-index width inside I_MEM (byte address bits MSB_I_MEM..2).
  localparam int WW = MSB_I_MEM - 1;
  localparam int TW = $clog2(RSP_TIMEOUT + 1);
  localparam logic [31:0]   REGION_BASE = 32'(I_MEM_REGION) << LSB_REGION;
  localparam logic [16:0]   MAX_LEN     = 17'(MAX_WORDS);
  localparam logic [TW-1:0] TO_LAST     = TW'(RSP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_DONE    = 3'd4
  } t_state;

  t_state        state;
  logic          verify_q;
  logic [WW-1:0] word_base;
  logic [15:0]   len_q;
  logic [15:0]   idx;
  logic [31:0]   exp_word;
  logic [TW-1:0] to_cnt;

  logic          req_valid;
  t_opcode       req_opcode;
  logic [31:0]   req_addr;
  logic [31:0]   req_data;
  logic          done;
  logic          error;
  logic [31:0]   err_addr;

  logic          last_word;

  // Ring address of word i: region bits OR the word offset, wrapping inside I_MEM.
  function automatic logic [31:0] word_addr(input logic [WW-1:0] wbase, input logic [15:0] i);
    logic [WW-1:0] w;
    w = wbase + WW'(i);
    return REGION_BASE | ({{(32-WW){1'b0}}, w} << 2);
  endfunction

  assign last_word = (idx == (len_q - 16'd1));

  // Control FSM with registered ring request and status outputs.
  always_ff @(posedge QClk) begin
    if (!RstQnnnH) begin
      state      <= S_IDLE;
      verify_q   <= 1'b0;
      word_base  <= '0;
      len_q      <= '0;
      idx        <= '0;
      exp_word   <= '0;
      to_cnt     <= '0;
      req_valid  <= 1'b0;
      req_opcode <= OP_RD;
      req_addr   <= '0;
      req_data   <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_addr   <= '0;
    end else begin
      req_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.StartQ500H) begin
            verify_q  <= bus.VerifyEnQ500H;
            word_base <= bus.BaseAddrQ500H[MSB_I_MEM:2];
            len_q     <= bus.LenWordsQ500H;
            idx       <= '0;
            error     <= 1'b0;
            err_addr  <= '0;
            if (bus.LenWordsQ500H == 16'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else if ({1'b0, bus.LenWordsQ500H} > MAX_LEN) begin
              error <= 1'b1;
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_WR;
            end
          end
        end

        S_WR: begin
          // Ready is high throughout WR, so valid alone marks a transfer.
          if (bus.SrcValidQ500H) begin
            req_valid  <= 1'b1;
            req_opcode <= OP_WR;
            req_addr   <= word_addr(word_base, idx);
            req_data   <= bus.SrcDataQ500H;
            if (last_word) begin
              idx <= '0;
              if (verify_q) begin
                state <= S_RD_REQ;
              end else begin
                state <= S_DONE;
                done  <= 1'b1;
              end
            end else begin
              idx <= idx + 16'd1;
            end
          end
        end

        S_RD_REQ: begin
          if (bus.SrcValidQ500H) begin
            exp_word   <= bus.SrcDataQ500H;
            req_valid  <= 1'b1;
            req_opcode <= OP_RD;
            req_addr   <= word_addr(word_base, idx);
            req_data   <= '0;
            to_cnt     <= '0;
            state      <= S_RD_WAIT;
          end
        end

        S_RD_WAIT: begin
          // req_addr still holds the outstanding read address here.
          if (bus.F2C_RspIMemValidQ504H) begin
            if (bus.F2C_I_MemRspDataQ504H == exp_word) begin
              if (last_word) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                idx   <= idx + 16'd1;
                state <= S_RD_REQ;
              end
            end else begin
              error    <= 1'b1;
              err_addr <= req_addr;
              state    <= S_DONE;
              done     <= 1'b1;
            end
          end else if (to_cnt == TO_LAST) begin
            error    <= 1'b1;
            err_addr <= req_addr;
            state    <= S_DONE;
            done     <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.SrcReadyQ500H       = (state == S_WR) || (state == S_RD_REQ);
  assign bus.BusyQ500H           = (state != S_IDLE);
  assign bus.F2C_ReqValidQ503H   = req_valid;
  assign bus.F2C_ReqOpcodeQ503H  = req_opcode;
  assign bus.F2C_ReqAddressQ503H = req_addr;
  assign bus.F2C_ReqDataQ503H    = req_data;
  assign bus.DoneQ500H           = done;
  assign bus.ErrorQ500H          = error;
  assign bus.ErrAddrQ500H        = err_addr;
  assign bus.DbgStateQ500H       = state;

endmodule

// File: tb/tb_i_mem_ring_loader.sv
// Directed bench for i_mem_ring_loader: write-only, verify pass, mismatch,
// timeout, length boundaries, ignored restart, source gaps, address wrap and
// reset during a write pass. A memory model answers reads one cycle after the
// request; a monitor pops every observed ring request against exp_q.

module tb_i_mem_ring_loader;

  localparam logic [31:0] RG = 32'h4000_0000;

  logic clk = 1'b0;
  logic rst_n;

  i_mem_ring_loader_if bus ();

  i_mem_ring_loader dut (
    .QClk     (clk),
    .RstQnnnH (rst_n),
    .bus      (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;

  logic [65:0] exp_q[$];
  int          req_cyc[$];
  logic [31:0] mem [logic [31:0]];
  logic        rd_pend = 1'b0;
  logic [31:0] pend_addr = '0;
  logic        silent = 1'b0;
  logic [31:0] corrupt_addr = 32'hFFFF_FFFF;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [65:0] mk(input t_opcode op, input logic [31:0] a, input logic [31:0] d);
    return {op, a, d};
  endfunction

  // ---------------- memory model + request scoreboard ----------------
  always @(negedge clk) begin
    logic [65:0] obs;
    logic [65:0] exp;
    if (rd_pend && !silent) begin
      bus.F2C_RspIMemValidQ504H = 1'b1;
      if (pend_addr == corrupt_addr)
        bus.F2C_I_MemRspDataQ504H = 32'hDEAD_BEEF;
      else
        bus.F2C_I_MemRspDataQ504H = mem.exists(pend_addr) ? mem[pend_addr] : 32'h0;
    end else begin
      bus.F2C_RspIMemValidQ504H = 1'b0;
      bus.F2C_I_MemRspDataQ504H = 32'h0;
    end
    rd_pend = 1'b0;
    if (bus.F2C_ReqValidQ503H) begin
      obs = {bus.F2C_ReqOpcodeQ503H, bus.F2C_ReqAddressQ503H, bus.F2C_ReqDataQ503H};
      req_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_req observed=%0h expected=none", obs);
      end else begin
        exp = exp_q.pop_front();
        check("req_op",   32'(obs[65:64]), 32'(exp[65:64]));
        check("req_addr", obs[63:32], exp[63:32]);
        check("req_data", obs[31:0],  exp[31:0]);
      end
      if (bus.F2C_ReqOpcodeQ503H == OP_WR) begin
        mem[bus.F2C_ReqAddressQ503H] = bus.F2C_ReqDataQ503H;
      end else begin
        rd_pend   = 1'b1;
        pend_addr = bus.F2C_ReqAddressQ503H;
      end
    end
    if (bus.DoneQ500H) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_op(input logic [31:0] base, input logic [15:0] len, input logic verify);
    bus.StartQ500H    = 1'b1;
    bus.BaseAddrQ500H = base;
    bus.LenWordsQ500H = len;
    bus.VerifyEnQ500H = verify;
    tick();
    bus.StartQ500H    = 1'b0;
  endtask

  // Offers one word; returns on the negedge right after the accepting edge.
  task automatic push_word(input logic [31:0] d);
    logic ok;
    ok = 1'b0;
    bus.SrcValidQ500H = 1'b1;
    bus.SrcDataQ500H  = d;
    for (int n = 0; n < 50; n++) begin
      ok = bus.SrcReadyQ500H;
      tick();
      if (ok) break;
    end
    bus.SrcValidQ500H = 1'b0;
    check("push_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input int bound, output int cycles);
    int n;
    n = 0;
    while (!bus.DoneQ500H && n < bound) begin
      tick();
      n++;
    end
    cycles = n;
    check("done_seen", 32'(bus.DoneQ500H), 32'd1);
    tick();
    check("done_pulse_end", 32'(bus.DoneQ500H), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int d0;
    rst_n = 1'b0;
    bus.StartQ500H    = 1'b0;
    bus.VerifyEnQ500H = 1'b0;
    bus.BaseAddrQ500H = '0;
    bus.LenWordsQ500H = '0;
    bus.SrcValidQ500H = 1'b0;
    bus.SrcDataQ500H  = '0;
    bus.F2C_RspIMemValidQ504H = 1'b0;
    bus.F2C_I_MemRspDataQ504H = '0;
    repeat (3) tick();

    // Reset state
    check("rst_busy",   32'(bus.BusyQ500H), 0);
    check("rst_done",   32'(bus.DoneQ500H), 0);
    check("rst_error",  32'(bus.ErrorQ500H), 0);
    check("rst_erraddr", bus.ErrAddrQ500H, 0);
    check("rst_reqv",   32'(bus.F2C_ReqValidQ503H), 0);
    check("rst_reqaddr", bus.F2C_ReqAddressQ503H, 0);
    check("rst_reqdata", bus.F2C_ReqDataQ503H, 0);
    check("rst_ready",  32'(bus.SrcReadyQ500H), 0);
    check("rst_state",  32'(bus.DbgStateQ500H), 0);
    rst_n = 1'b1;
    tick();

    // Write only, back-to-back words
    start_op(32'h40, 16'd3, 1'b0);
    check("t1_busy",  32'(bus.BusyQ500H), 1);
    check("t1_ready", 32'(bus.SrcReadyQ500H), 1);
    exp_q.push_back(mk(OP_WR, RG | 32'h40, 32'hAAAA_0001));
    exp_q.push_back(mk(OP_WR, RG | 32'h44, 32'hBBBB_0002));
    exp_q.push_back(mk(OP_WR, RG | 32'h48, 32'hCCCC_0003));
    req_cyc.delete();
    push_word(32'hAAAA_0001);
    push_word(32'hBBBB_0002);
    push_word(32'hCCCC_0003);
    check("t1_done", 32'(bus.DoneQ500H), 1);
    tick();
    check("t1_done_end", 32'(bus.DoneQ500H), 0);
    check("t1_idle",  32'(bus.BusyQ500H), 0);
    check("t1_error", 32'(bus.ErrorQ500H), 0);
    check("t1_exp_left", 32'(exp_q.size()), 0);
    check("t1_req_count", 32'(req_cyc.size()), 3);
    if (req_cyc.size() == 3) begin
      check("t1_req_gap01", 32'(req_cyc[1] - req_cyc[0]), 1);
      check("t1_req_gap12", 32'(req_cyc[2] - req_cyc[1]), 1);
    end

    // Verify pass, all words read back correctly
    start_op(32'h0, 16'd2, 1'b1);
    exp_q.push_back(mk(OP_WR, RG | 32'h0, 32'h1111_1111));
    exp_q.push_back(mk(OP_WR, RG | 32'h4, 32'h2222_2222));
    exp_q.push_back(mk(OP_RD, RG | 32'h0, 32'h0));
    exp_q.push_back(mk(OP_RD, RG | 32'h4, 32'h0));
    push_word(32'h1111_1111);
    push_word(32'h2222_2222);
    check("t2_rdreq_ready", 32'(bus.SrcReadyQ500H), 1);
    push_word(32'h1111_1111);
    check("t2_rdwait_ready", 32'(bus.SrcReadyQ500H), 0);
    push_word(32'h2222_2222);
    wait_done(30, n);
    check("t2_error",   32'(bus.ErrorQ500H), 0);
    check("t2_erraddr", bus.ErrAddrQ500H, 0);
    check("t2_exp_left", 32'(exp_q.size()), 0);

    // Mismatch on word 1 stops the read pass
    corrupt_addr = RG | 32'h4;
    start_op(32'h0, 16'd3, 1'b1);
    exp_q.push_back(mk(OP_WR, RG | 32'h0, 32'h0BAD_F00D));
    exp_q.push_back(mk(OP_WR, RG | 32'h4, 32'h1234_5678));
    exp_q.push_back(mk(OP_WR, RG | 32'h8, 32'h7777_7777));
    exp_q.push_back(mk(OP_RD, RG | 32'h0, 32'h0));
    exp_q.push_back(mk(OP_RD, RG | 32'h4, 32'h0));
    push_word(32'h0BAD_F00D);
    push_word(32'h1234_5678);
    push_word(32'h7777_7777);
    push_word(32'h0BAD_F00D);
    push_word(32'h1234_5678);
    wait_done(30, n);
    check("t3_error",   32'(bus.ErrorQ500H), 1);
    check("t3_erraddr", bus.ErrAddrQ500H, RG | 32'h4);
    repeat (4) tick();
    check("t3_error_sticky", 32'(bus.ErrorQ500H), 1);
    check("t3_idle", 32'(bus.BusyQ500H), 0);
    check("t3_exp_left", 32'(exp_q.size()), 0);
    corrupt_addr = 32'hFFFF_FFFF;

    // Silent responder: timeout after RSP_TIMEOUT cycles in RD_WAIT
    silent = 1'b1;
    start_op(32'h100, 16'd1, 1'b1);
    check("t4_error_cleared",   32'(bus.ErrorQ500H), 0);
    check("t4_erraddr_cleared", bus.ErrAddrQ500H, 0);
    exp_q.push_back(mk(OP_WR, RG | 32'h100, 32'h5A5A_5A5A));
    exp_q.push_back(mk(OP_RD, RG | 32'h100, 32'h0));
    push_word(32'h5A5A_5A5A);
    push_word(32'h5A5A_5A5A);
    check("t4_waiting", 32'(bus.DbgStateQ500H), 3);
    wait_done(40, n);
    check("t4_timeout_cycles", 32'(n), 8);
    check("t4_error",   32'(bus.ErrorQ500H), 1);
    check("t4_erraddr", bus.ErrAddrQ500H, RG | 32'h100);
    check("t4_exp_left", 32'(exp_q.size()), 0);
    silent = 1'b0;

    // Length beyond MAX_WORDS: immediate Done with error, address 0
    start_op(32'h40, 16'd1025, 1'b0);
    check("t5_done",    32'(bus.DoneQ500H), 1);
    check("t5_busy",    32'(bus.BusyQ500H), 1);
    check("t5_error",   32'(bus.ErrorQ500H), 1);
    check("t5_erraddr", bus.ErrAddrQ500H, 0);
    tick();
    check("t5_idle", 32'(bus.BusyQ500H), 0);

    // Zero length: immediate Done, no requests, error cleared
    start_op(32'h40, 16'd0, 1'b1);
    check("t6_done",  32'(bus.DoneQ500H), 1);
    check("t6_error", 32'(bus.ErrorQ500H), 0);
    tick();
    check("t6_done_end", 32'(bus.DoneQ500H), 0);
    check("t6_idle", 32'(bus.BusyQ500H), 0);

    // Start while busy ignored; source gaps give no spurious requests
    start_op(32'h200, 16'd2, 1'b0);
    exp_q.push_back(mk(OP_WR, RG | 32'h200, 32'hD0D0_0000));
    exp_q.push_back(mk(OP_WR, RG | 32'h204, 32'hD0D0_0001));
    start_op(32'h300, 16'd5, 1'b1);
    check("t7_still_wr", 32'(bus.DbgStateQ500H), 1);
    push_word(32'hD0D0_0000);
    check("t7_req_issued", 32'(bus.F2C_ReqValidQ503H), 1);
    for (int g = 0; g < 3; g++) begin
      tick();
      check("t7_gap_reqv", 32'(bus.F2C_ReqValidQ503H), 0);
    end
    push_word(32'hD0D0_0001);
    check("t7_done", 32'(bus.DoneQ500H), 1);
    tick();
    check("t7_exp_left", 32'(exp_q.size()), 0);

    // Address wraps at the top of I_MEM; base bits outside the word field ignored
    start_op(32'h1234_FFFE, 16'd2, 1'b0);
    exp_q.push_back(mk(OP_WR, RG | 32'hFFFC, 32'hE000_0001));
    exp_q.push_back(mk(OP_WR, RG | 32'h0000, 32'hE000_0002));
    push_word(32'hE000_0001);
    push_word(32'hE000_0002);
    check("t8_done", 32'(bus.DoneQ500H), 1);
    tick();
    check("t8_exp_left", 32'(exp_q.size()), 0);

    // Reset while word 2 of 4 is offered
    start_op(32'h80, 16'd4, 1'b0);
    exp_q.push_back(mk(OP_WR, RG | 32'h80, 32'hF000_0000));
    push_word(32'hF000_0000);
    d0 = done_cnt;
    bus.SrcValidQ500H = 1'b1;
    bus.SrcDataQ500H  = 32'hF000_0001;
    rst_n = 1'b0;
    tick();
    check("t9_busy",  32'(bus.BusyQ500H), 0);
    check("t9_reqv",  32'(bus.F2C_ReqValidQ503H), 0);
    check("t9_done",  32'(bus.DoneQ500H), 0);
    check("t9_ready", 32'(bus.SrcReadyQ500H), 0);
    bus.SrcValidQ500H = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    check("t9_no_done", 32'(done_cnt - d0), 0);
    check("t9_exp_left", 32'(exp_q.size()), 0);

    // Normal run after the abort
    start_op(32'h80, 16'd1, 1'b1);
    exp_q.push_back(mk(OP_WR, RG | 32'h80, 32'h9999_0009));
    exp_q.push_back(mk(OP_RD, RG | 32'h80, 32'h0));
    push_word(32'h9999_0009);
    push_word(32'h9999_0009);
    wait_done(30, n);
    check("t10_error", 32'(bus.ErrorQ500H), 0);
    check("t10_exp_left", 32'(exp_q.size()), 0);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i_mem_ring_loader.md
I_MEM_RING_LOADER -- requirements
Module: i_mem_ring_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 1024, maximum legal LenWordsQ500H.
REQ-002 SHALL have parameter RSP_TIMEOUT, default 8, cycles to wait for a read response before declaring error.
REQ-003 SHALL have port QClk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port RstQnnnH  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port StartQ500H  input  1  one-cycle start pulse.
REQ-006 SHALL have port VerifyEnQ500H  input  1  sampled with Start; 1 = run read-back pass after write pass.
REQ-007 SHALL have port BaseAddrQ500H  input  32  byte offset of first word, sampled with Start, bits [1:0] ignored.
REQ-008 SHALL have port LenWordsQ500H  input  16  word count, sampled with Start.
REQ-009 SHALL have ports SrcValidQ500H input 1, SrcDataQ500H input 32, SrcReadyQ500H output 1  word-source handshake.
REQ-010 SHALL have ports F2C_ReqValidQ503H output 1, F2C_ReqOpcodeQ503H output t_opcode, F2C_ReqAddressQ503H output 32, F2C_ReqDataQ503H output 32  ring request to I_MEM.
REQ-011 SHALL have ports F2C_RspIMemValidQ504H input 1, F2C_I_MemRspDataQ504H input 32  ring read response.
REQ-012 SHALL have ports BusyQ500H output 1, DoneQ500H output 1 (pulse), ErrorQ500H output 1 (sticky), ErrAddrQ500H output 32.

Function
REQ-013 SHALL implement FSM states IDLE, WR, RD_REQ, RD_WAIT, DONE.
REQ-014 SHALL in IDLE on StartQ500H latch base, length, verify flag, clear ErrorQ500H/ErrAddrQ500H, clear word counter, go WR; Start while not IDLE SHALL be ignored.
REQ-015 SHALL with LenWordsQ500H==0 or >MAX_WORDS go IDLE->DONE without any ring request; >MAX_WORDS additionally sets ErrorQ500H, ErrAddrQ500H=0.
REQ-016 SHALL form request address = {I_MEM_REGION in [MSB_REGION:LSB_REGION], zero elsewhere} OR (base[MSB_I_MEM:2]+idx)<<2, wrapping modulo I_MEM size.
REQ-017 SHALL in WR assert SrcReadyQ500H; on SrcValid&&SrcReady drive registered request next cycle: ReqValid=1, opcode WR, address per idx, data=SrcData; idx increments.
REQ-018 SHALL drive F2C_ReqValidQ503H exactly one cycle per accepted word; ring accepts every request, no backpressure.
REQ-019 SHALL leave WR after last word accepted: to RD_REQ (idx reset to 0) if verify flag, else DONE.
REQ-020 SHALL in RD_REQ assert SrcReadyQ500H; on handshake store SrcData as expected word, issue registered RD request next cycle (ReqData=0), go RD_WAIT, SrcReady deasserted.
REQ-021 SHALL allow at most one outstanding read; SrcReadyQ500H=0 in RD_WAIT, DONE, IDLE.
REQ-022 SHALL in RD_WAIT on F2C_RspIMemValidQ504H compare F2C_I_MemRspDataQ504H to expected: equal -> next word RD_REQ or DONE after last; unequal -> set ErrorQ500H, ErrAddrQ500H=request address, go DONE.
REQ-023 SHALL count RD_WAIT cycles; reaching RSP_TIMEOUT without response sets ErrorQ500H, ErrAddrQ500H=request address, go DONE.
REQ-024 SHALL ignore F2C_RspIMemValidQ504H outside RD_WAIT.
REQ-025 SHALL in DONE pulse DoneQ500H one cycle and return IDLE.
REQ-026 SHALL hold BusyQ500H=1 in all states except IDLE.
REQ-027 SHALL hold ErrorQ500H and ErrAddrQ500H until next accepted Start.

Reset
REQ-028 SHALL on RstQnnnH==0 at a rising edge go IDLE, zero counters, and drive every output 0 (opcode RD encoding irrelevant while ReqValid=0) the following cycle.
REQ-029 SHALL on reset mid-operation abort without issuing further requests; no DoneQ500H pulse.

Verification
REQ-030 Write only: Start, base 0x40, len 3, verify 0, words A,B,C back-to-back -> three WR requests on consecutive cycles, addresses region|0x40/0x44/0x48, Done pulse, Error 0.
REQ-031 Verify pass: base 0, len 2, verify 1, memory model responds 1 cycle later -> 2 WR, then RD/rsp pairs, Done, Error 0.
REQ-032 Mismatch: memory returns 0xDEADBEEF for word 1 expected 0x12345678 at offset 0x4 -> Error 1, ErrAddr region|0x4, Done, no further RD.
REQ-033 Timeout: responder silent -> after 8 RD_WAIT cycles Error 1, Done pulse.
REQ-034 Boundaries: len 0 -> Done next state, no requests; Start while Busy ignored; SrcValid gaps stall WR without spurious ReqValid.
REQ-035 Reset asserted during WR of word 2 of 4 -> next cycle Busy 0, ReqValid 0, no Done; subsequent Start runs normally.
